tl_burst_arbiter: RTL and testbench

Parametrised N-to-1 TileLink channel arbiter that keeps multi-beat messages atomic on the output. It counts beats from `size` and the bus width, and it selects round-robin or fixed-priority arbitration. It sits in the `tl_xbar` layer, in front of each shared A/B/C/D output port. It replaces per-channel single-mode arbiters and exports grant and last-beat information for downstream routing.

---
 rtl/tl_burst_arbiter_pkg.sv | 29 ++
 rtl/tl_burst_arbiter_if.sv | 33 +++
 rtl/tl_rr_pick.sv | 36 +++
 rtl/tl_burst_arbiter.sv | 93 +++++++++
 tb/tb_tl_burst_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_burst_arbiter_pkg.sv
// tl_burst_arbiter_pkg: shared TileLink types and beat-count helpers for the burst arbiter
//   tl_chan_e   : channel selector (A..E), decides which opcodes carry data
//   arb_mode_e  : round-robin or fixed (lowest index) arbitration
//   tl_msg_t    : default message layout (opcode, size, data)
package tl_burst_arbiter_pkg;

    typedef enum logic [2:0] {TL_CH_A, TL_CH_B, TL_CH_C, TL_CH_D, TL_CH_E} tl_chan_e;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [31:0] data;
    } tl_msg_t;

    // A/B: Put{Full,Partial}Data, ArithmeticData, LogicalData are opcodes 0..3.
    // C: ProbeAckData=5, ReleaseData=7. D: AccessAckData=1, GrantData=5. E never carries data.
    function automatic logic tl_has_data(tl_chan_e chan, logic [2:0] opcode);
        return (chan == TL_CH_A || chan == TL_CH_B) ? (opcode <= 3'd3) :
               (chan == TL_CH_C) ? (opcode == 3'd5 || opcode == 3'd7) :
               (chan == TL_CH_D) ? (opcode == 3'd1 || opcode == 3'd5) : 1'b0;
    endfunction

    function automatic int tl_beats(int size, int beat_log2);
        return (size <= beat_log2) ? 1 : (1 << (size - beat_log2));
    endfunction

endpackage

// File: rtl/tl_burst_arbiter_if.sv
// tl_burst_arbiter_if: N-input to 1-output TileLink channel bundle
//   inp_bits_i/inp_valid_i/inp_ready_o : per-input message handshake
//   oup_bits_o/oup_valid_o/oup_ready_i : granted output handshake
//   grant_idx_o, oup_first_o, oup_last_o : grant index and beat position of the output
interface tl_burst_arbiter_if
    import tl_burst_arbiter_pkg::*;
#(
    parameter int  N_IN   = 2,
    parameter type DATA_T = tl_msg_t
) ();
    localparam int IDX_W = N_IN > 1 ? $clog2(N_IN) : 1;

    DATA_T [N_IN-1:0] inp_bits_i;
    logic  [N_IN-1:0] inp_valid_i;
    logic  [N_IN-1:0] inp_ready_o;
    DATA_T            oup_bits_o;
    logic             oup_valid_o;
    logic             oup_ready_i;
    logic [IDX_W-1:0] grant_idx_o;
    logic             oup_first_o;
    logic             oup_last_o;

    modport slave (
        input  inp_bits_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_bits_o, oup_valid_o, grant_idx_o, oup_first_o, oup_last_o
    );

    modport master (
        output inp_bits_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_bits_o, oup_valid_o, grant_idx_o, oup_first_o, oup_last_o
    );

endinterface

// File: rtl/tl_rr_pick.sv
// tl_rr_pick: combinational rotate-priority picker
//   req  : request vector
//   ptr  : search start index (round-robin mode only)
//   mode : ARB_RR searches from ptr, ARB_FIXED searches from index 0
//   gnt  : one-hot grant (zero when nothing requests)
//   idx  : index of the grant (0 when nothing requests)
module tl_rr_pick
    import tl_burst_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    int   j;
    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (mode == ARB_RR) ? (int'(ptr) + k) % N : k;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        gnt = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/tl_burst_arbiter.sv
// tl_burst_arbiter: N-to-1 TileLink channel arbiter that keeps multi-beat messages atomic
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : per-input bits/valid/ready in, granted bits/valid/ready out,
//                  grant index and first/last-beat flags for downstream routing
module tl_burst_arbiter
    import tl_burst_arbiter_pkg::*;
#(
    parameter int        N_IN       = 2,
    parameter type       DATA_T     = tl_msg_t,
    parameter tl_chan_e  CHANNEL    = TL_CH_A,
    parameter int        BEAT_BYTES = 8,
    parameter int        MAX_SIZE   = 6,
    parameter arb_mode_e ARB_MODE   = ARB_RR
) (
    input logic clk_i,
    input logic rst_i,
    tl_burst_arbiter_if.slave bus
);
    localparam int IDX_W     = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int BEAT_LOG2 = $clog2(BEAT_BYTES);
    localparam int CNT_W     = MAX_SIZE - BEAT_LOG2 > 1 ? MAX_SIZE - BEAT_LOG2 : 1;
    localparam int BW        = CNT_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] pick_idx, win, win_nxt;
    logic [N_IN-1:0]  pick_gnt;
    logic [BW-1:0]    beats;
    DATA_T            cur_bits;
    logic             hs;

    tl_rr_pick #(.N(N_IN), .IDX_W(IDX_W)) u_pick (
        .req  (bus.inp_valid_i),
        .ptr  (rr_ptr_q),
        .mode (ARB_MODE),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // During a burst the grant is pinned to the locked input, even while it is not valid.
    assign win      = state_q == BURST ? lock_idx_q : pick_idx;
    assign cur_bits = bus.inp_bits_i[win];
    assign beats    = tl_has_data(CHANNEL, cur_bits.opcode)
                    ? BW'(tl_beats(int'(cur_bits.size), BEAT_LOG2)) : BW'(1);
    assign win_nxt  = win == IDX_W'(N_IN - 1) ? '0 : win + IDX_W'(1);
    assign hs       = bus.oup_valid_o & bus.oup_ready_i;

    assign bus.oup_valid_o = bus.inp_valid_i[win];
    assign bus.oup_bits_o  = cur_bits;
    assign bus.grant_idx_o = win;
    assign bus.oup_first_o = state_q == IDLE;
    assign bus.oup_last_o  = state_q == IDLE ? beats == BW'(1) : cnt_q == CNT_W'(1);
    assign bus.inp_ready_o = state_q == BURST ? N_IN'(bus.oup_ready_i) << lock_idx_q
                                              : pick_gnt & {N_IN{bus.oup_ready_i}};

    // A handshake on the last beat completes the message: back to IDLE and advance the
    // round-robin pointer past the winner. Any other handshake (re)enters BURST.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (hs) begin
            cnt_d      = state_q == IDLE ? CNT_W'(beats - BW'(1)) : cnt_q - CNT_W'(1);
            lock_idx_d = win;
            state_d    = bus.oup_last_o ? IDLE : BURST;
            rr_ptr_d   = bus.oup_last_o ? win_nxt : rr_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    a_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.oup_valid_o |-> int'(cur_bits.size) <= MAX_SIZE);

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// tb_tl_burst_arbiter: directed and randomized checks of the burst arbiter in RR and FIXED modes
module tb_tl_burst_arbiter;
    import tl_burst_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl_msg_t [3:0] bin;
    logic    [3:0] vin;
    logic          rdy;

    tl_burst_arbiter_if #(.N_IN(4), .DATA_T(tl_msg_t)) bus_rr ();
    tl_burst_arbiter_if #(.N_IN(4), .DATA_T(tl_msg_t)) bus_fx ();

    assign bus_rr.inp_bits_i  = bin;
    assign bus_rr.inp_valid_i = vin;
    assign bus_rr.oup_ready_i = rdy;
    assign bus_fx.inp_bits_i  = bin;
    assign bus_fx.inp_valid_i = vin;
    assign bus_fx.oup_ready_i = rdy;

    tl_burst_arbiter #(.N_IN(4), .DATA_T(tl_msg_t), .CHANNEL(TL_CH_A), .BEAT_BYTES(8),
                       .MAX_SIZE(6), .ARB_MODE(ARB_RR)) dut_rr (
        .clk_i(clk), .rst_i(rst), .bus(bus_rr));

    tl_burst_arbiter #(.N_IN(4), .DATA_T(tl_msg_t), .CHANNEL(TL_CH_A), .BEAT_BYTES(8),
                       .MAX_SIZE(6), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk_i(clk), .rst_i(rst), .bus(bus_fx));

    logic          av[2], af[2], al[2];
    logic    [3:0] ar[2];
    logic    [1:0] ai[2];
    tl_msg_t       ab[2];

    assign av[0] = bus_rr.oup_valid_o;  assign av[1] = bus_fx.oup_valid_o;
    assign af[0] = bus_rr.oup_first_o;  assign af[1] = bus_fx.oup_first_o;
    assign al[0] = bus_rr.oup_last_o;   assign al[1] = bus_fx.oup_last_o;
    assign ar[0] = bus_rr.inp_ready_o;  assign ar[1] = bus_fx.inp_ready_o;
    assign ai[0] = bus_rr.grant_idx_o;  assign ai[1] = bus_fx.grant_idx_o;
    assign ab[0] = bus_rr.oup_bits_o;   assign ab[1] = bus_fx.oup_bits_o;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, a, e);
        end
    endtask

    // Reference model: per DUT, "is a message in flight, whose, how many beats remain
    // (including the one on the bus), where the next search starts".
    logic m_busy[2];
    int   m_own[2], m_left[2], m_ptr[2];
    logic m_ok = 1'b0;
    logic rand_en = 1'b0;
    int   src_left[4];
    logic [2:0] src_op[4];
    logic [3:0] src_sz[4];

    function automatic int beats_of(logic [2:0] op, logic [3:0] sz);
        return (op > 3'd3 || sz <= 4'd3) ? 1 : 1 << (int'(sz) - 3);
    endfunction

    function automatic int exp_win(int d);
        if (m_busy[d]) return m_own[d];
        for (int k = 0; k < 4; k++)
            if (vin[d == 0 ? (m_ptr[d] + k) % 4 : k]) return d == 0 ? (m_ptr[d] + k) % 4 : k;
        return 0;
    endfunction

    int uw;
    always @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0; m_own[d] = 0; m_left[d] = 0; m_ptr[d] = 0;
            end
            m_ok = 1'b1;
        end else if (m_ok) begin
            for (int d = 0; d < 2; d++) begin
                uw = exp_win(d);
                if (vin[uw] && rdy) begin
                    if (d == 0 && rand_en && src_left[uw] > 0) src_left[uw]--;
                    if (m_busy[d]) begin
                        m_left[d]--;
                        if (m_left[d] == 0) begin
                            m_busy[d] = 1'b0;
                            m_ptr[d]  = (m_own[d] + 1) % 4;
                        end
                    end else if (beats_of(bin[uw].opcode, bin[uw].size) > 1) begin
                        m_busy[d] = 1'b1;
                        m_own[d]  = uw;
                        m_left[d] = beats_of(bin[uw].opcode, bin[uw].size) - 1;
                    end else begin
                        m_ptr[d] = (uw + 1) % 4;
                    end
                end
            end
        end
    end

    int         cw;
    logic [3:0] er;
    always @(negedge clk) begin
        if (m_ok) begin
            for (int d = 0; d < 2; d++) begin
                cw = exp_win(d);
                er = m_busy[d] ? 4'(rdy) << m_own[d] : (rdy && vin != 4'b0) ? 4'b0001 << cw : 4'b0;
                chk($sformatf("m%0d_valid", d), 64'(av[d]), 64'(vin[cw]));
                if (vin[cw]) chk($sformatf("m%0d_bits", d), 64'(ab[d]), 64'(bin[cw]));
                chk($sformatf("m%0d_ready", d), 64'(ar[d]), 64'(er));
                chk($sformatf("m%0d_idx", d), 64'(ai[d]), 64'(cw));
                chk($sformatf("m%0d_first", d), 64'(af[d]), 64'(!m_busy[d]));
                chk($sformatf("m%0d_last", d), 64'(al[d]),
                    64'(m_busy[d] ? m_left[d] == 1 : beats_of(bin[cw].opcode, bin[cw].size) == 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [2:0] op, input logic [3:0] sz);
        bin[i].opcode = op;
        bin[i].size   = sz;
        bin[i].data   = $urandom;
    endtask

    task automatic rst_pulse();
        rst = 1'b1; rdy = 1'b0; vin = 4'b0;
        step();
        rst = 1'b0;
    endtask

    int   hs_n, c;
    logic done;
    logic [1:0] exit_idx;

    initial begin
        bin = '0; vin = 4'b0; rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin src_left[i] = 0; src_op[i] = 3'd0; src_sz[i] = 4'd0; end
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(bus_rr.oup_valid_o), 64'd0);
        chk("rst_ready", 64'(bus_rr.inp_ready_o), 64'd0);
        chk("rst_idx",   64'(bus_rr.grant_idx_o), 64'd0);
        chk("rst_first", 64'(bus_rr.oup_first_o), 64'd1);
        chk("rst_last",  64'(bus_rr.oup_last_o),  64'd1);
        step();

        // four continuous single-beat Gets rotate 0,1,2,3,0
        for (int i = 0; i < 4; i++) put(i, 3'd4, 4'd0);
        vin = 4'b1111; rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr_order%0d", k), 64'(bus_rr.grant_idx_o), 64'(k % 4));
            step();
        end

        // 8-beat PutFullData on input 1 with input 2 waiting
        rst_pulse();
        put(1, 3'd0, 4'd6); put(2, 3'd4, 4'd0);
        vin = 4'b0110; rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("burst_idx%0d", k), 64'(bus_rr.grant_idx_o), 64'(k < 8 ? 1 : 2));
            if (k < 8) begin
                chk($sformatf("burst_first%0d", k), 64'(bus_rr.oup_first_o), 64'(k == 0));
                chk($sformatf("burst_last%0d", k),  64'(bus_rr.oup_last_o),  64'(k == 7));
            end
            step();
        end

        // same burst, ready toggling and input 1 dropping valid for 3 cycles
        rst_pulse();
        put(1, 3'd0, 4'd6); put(2, 3'd4, 4'd0);
        vin = 4'b0110;
        hs_n = 0; c = 0; done = 1'b0; exit_idx = 2'd1;
        while (c < 40 && !done) begin
            rdy = (c % 2 == 0);
            vin[1] = !(c >= 4 && c <= 6);
            @(negedge clk);
            if (bus_rr.grant_idx_o != 2'd1) begin
                done = 1'b1;
                exit_idx = bus_rr.grant_idx_o;
            end else begin
                if (!vin[1]) chk("stall_valid", 64'(bus_rr.oup_valid_o), 64'd0);
                if (bus_rr.oup_valid_o && rdy) hs_n++;
            end
            step();
            c++;
        end
        chk("stall_beats", 64'(hs_n), 64'd8);
        chk("stall_exit_idx", 64'(exit_idx), 64'd2);

        // Get with size 6 is a single beat
        rst_pulse();
        put(0, 3'd4, 4'd6);
        vin = 4'b0001; rdy = 1'b1;
        @(negedge clk);
        chk("get6_first", 64'(bus_rr.oup_first_o), 64'd1);
        chk("get6_last",  64'(bus_rr.oup_last_o),  64'd1);
        step();
        vin = 4'b0;
        @(negedge clk);
        chk("get6_noburst_first", 64'(bus_rr.oup_first_o), 64'd1);
        chk("get6_noburst_last",  64'(bus_rr.oup_last_o),  64'd1);
        step();

        // fixed priority: input 0 always wins over input 3
        put(0, 3'd4, 4'd0); put(3, 3'd4, 4'd0);
        vin = 4'b1001; rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("fixed_idx%0d", k), 64'(bus_fx.grant_idx_o), 64'd0);
            step();
        end

        // reset after beat 3 drops the lock; input 2 is granted straight away
        rst_pulse();
        put(1, 3'd0, 4'd6);
        vin = 4'b0010; rdy = 1'b1;
        step(); step(); step();
        rst = 1'b1;
        put(2, 3'd4, 4'd0);
        vin = 4'b0100;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idx",   64'(bus_rr.grant_idx_o), 64'd2);
        chk("midrst_valid", 64'(bus_rr.oup_valid_o), 64'd1);
        chk("midrst_first", 64'(bus_rr.oup_first_o), 64'd1);
        chk("midrst_ready", 64'(bus_rr.inp_ready_o), 64'b0100);
        step();

        // randomized traffic, checked every cycle against the model
        rand_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) begin
                if (src_left[i] == 0) begin
                    src_op[i]   = 3'($urandom_range(0, 7));
                    src_sz[i]   = 4'($urandom_range(0, 6));
                    src_left[i] = beats_of(src_op[i], src_sz[i]);
                end
                vin[i] = ($urandom_range(0, 3) != 0);
                put(i, src_op[i], src_sz[i]);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
